bsg_demodulator: RTL and testbench

- Receive-side counterpart of the BSG modulator: recovers DATA_WIDTH-bit words from the Manchester-coded serial line the transmitter drives.
- Sits in the receive clock domain ahead of the BSG register and control logic.
- Synchronises the line, recovers chip timing, hunts for the sync word, then decodes one data word per frame.
- Flags Manchester code violations.

---
 rtl/bsg_demodulator.sv | 163 ++++++++++++++++
 tb/tb_bsg_demodulator.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/bsg_demodulator.sv
// rtl/bsg_demodulator.sv - Manchester receive demodulator: line sync, chip timing, sync hunt, word decode
// Optional feature macro: BSG_RX_PARITY_EN (even parity bit after the data word)
module bsg_demodulator #(
  parameter int          DATA_WIDTH  = 8,
  parameter int          HALF_PERIOD = 4,
  parameter logic [7:0]  SYNC_WORD   = 8'hD5
) (
  input  logic                  G_CLK_RX,
  input  logic                  rst,
  input  logic                  enable,
  input  logic                  rx_in,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic                  data_valid,
  output logic                  code_err,
  output logic                  busy
);

  localparam int CW = $clog2(HALF_PERIOD);
`ifdef BSG_RX_PARITY_EN
  localparam int NBITS = DATA_WIDTH + 1;
`else
  localparam int NBITS = DATA_WIDTH;
`endif
  localparam int BW = $clog2(NBITS + 1);

  // Bit 1 -> chips 0,1 ; bit 0 -> chips 1,0 ; first chip lands in the MSB
  function automatic logic [15:0] manchester(input logic [7:0] w);
    logic [15:0] m;
    m = '0;
    for (int i = 0; i < 8; i++) begin
      m[2*i +: 2] = w[i] ? 2'b01 : 2'b10;
    end
    return m;
  endfunction

  localparam logic [15:0] SYNC_CHIPS = manchester(SYNC_WORD);

  typedef enum logic {HUNT, DATA} state_e;

  logic                  rx_m_q, rx_s_q;
  logic [CW-1:0]         cnt_q;
  state_e                state_q;
  logic [15:0]           chip_sr_q;
  logic [BW-1:0]         bit_cnt_q;
  logic                  phase_q;
  logic                  first_q;
  logic [DATA_WIDTH-1:0] word_q;
  logic [DATA_WIDTH-1:0] data_out_q;
  logic                  data_valid_q;
  logic                  code_err_q;

  logic line_edge;
  logic chip_stb;

  // rx_s is about to change: restart chip timing so cnt is 0 in the first cycle of the new chip
  assign line_edge = rx_m_q ^ rx_s_q;
  assign chip_stb  = (cnt_q == CW'(HALF_PERIOD / 2));

  // Two-flop synchroniser for the asynchronous line
  always_ff @(posedge G_CLK_RX) begin
    if (rst) begin
      rx_m_q <= 1'b0;
      rx_s_q <= 1'b0;
    end else begin
      rx_m_q <= rx_in;
      rx_s_q <= rx_m_q;
    end
  end

  // Chip phase counter, free-running and resynchronised on every line transition
  always_ff @(posedge G_CLK_RX) begin
    if (rst || line_edge || cnt_q == CW'(HALF_PERIOD - 1)) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

  // Hunt/decode FSM with registered outputs
  always_ff @(posedge G_CLK_RX) begin
    if (rst) begin
      state_q      <= HUNT;
      chip_sr_q    <= '0;
      bit_cnt_q    <= '0;
      phase_q      <= 1'b0;
      first_q      <= 1'b0;
      word_q       <= '0;
      data_out_q   <= '0;
      data_valid_q <= 1'b0;
      code_err_q   <= 1'b0;
    end else begin
      data_valid_q <= 1'b0;
      code_err_q   <= 1'b0;
      if (!enable) begin
        state_q   <= HUNT;
        chip_sr_q <= '0;
        bit_cnt_q <= '0;
        phase_q   <= 1'b0;
        word_q    <= '0;
      end else begin
        case (state_q)
          HUNT: begin
            // The match is seen the cycle after the last sync chip shifts, well before the next strobe
            if (chip_sr_q == SYNC_CHIPS) begin
              state_q   <= DATA;
              chip_sr_q <= '0;
              bit_cnt_q <= '0;
              phase_q   <= 1'b0;
              word_q    <= '0;
            end else if (chip_stb) begin
              chip_sr_q <= {chip_sr_q[14:0], rx_s_q};
            end
          end
          DATA: begin
            if (chip_stb) begin
              if (!phase_q) begin
                first_q <= rx_s_q;
                phase_q <= 1'b1;
              end else begin
                phase_q <= 1'b0;
                if (first_q == rx_s_q) begin
                  code_err_q <= 1'b1;
                  state_q    <= HUNT;
                  chip_sr_q  <= '0;
                  bit_cnt_q  <= '0;
                  word_q     <= '0;
                end else if (bit_cnt_q == BW'(NBITS - 1)) begin
`ifdef BSG_RX_PARITY_EN
                  // Final pair carries the even parity bit over the already complete word
                  if ((^word_q) == rx_s_q) begin
                    data_out_q   <= word_q;
                    data_valid_q <= 1'b1;
                  end else begin
                    code_err_q <= 1'b1;
                  end
`else
                  data_out_q   <= {word_q[DATA_WIDTH-2:0], rx_s_q};
                  data_valid_q <= 1'b1;
`endif
                  state_q   <= HUNT;
                  chip_sr_q <= '0;
                  bit_cnt_q <= '0;
                  word_q    <= '0;
                end else begin
                  // Valid pair: the second chip equals the bit value
                  word_q    <= {word_q[DATA_WIDTH-2:0], rx_s_q};
                  bit_cnt_q <= bit_cnt_q + 1'b1;
                end
              end
            end
          end
          default: state_q <= HUNT;
        endcase
      end
    end
  end

  assign data_out   = data_out_q;
  assign data_valid = data_valid_q;
  assign code_err   = code_err_q;
  assign busy       = (state_q == DATA);

endmodule

// File: tb/tb_bsg_demodulator.sv
// tb/tb_bsg_demodulator.sv - directed self-checking bench for bsg_demodulator
module tb_bsg_demodulator;

  localparam int HP = 4;

  logic       clk = 1'b0;
  logic       rst;
  logic       enable;
  logic       rx_in;
  logic [7:0] data_out;
  logic       data_valid;
  logic       code_err;
  logic       busy;

  int n_checks = 0;
  int n_errs   = 0;

  int         dv_cnt  = 0;
  int         err_cnt = 0;
  bit         both_seen = 1'b0;
  logic [7:0] dv_log[$];

  bit jit  = 1'b0;
  bit jtog = 1'b0;

  bsg_demodulator #(.DATA_WIDTH(8), .HALF_PERIOD(HP), .SYNC_WORD(8'hD5)) dut (
    .G_CLK_RX   (clk),
    .rst        (rst),
    .enable     (enable),
    .rx_in      (rx_in),
    .data_out   (data_out),
    .data_valid (data_valid),
    .code_err   (code_err),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  // Pulse bookkeeping sampled on the falling edge
  always @(negedge clk) begin
    if (data_valid) begin
      dv_cnt++;
      dv_log.push_back(data_out);
    end
    if (code_err) err_cnt++;
    if (data_valid && code_err) both_seen = 1'b1;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errs++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Hold one chip; in jitter mode lengths alternate HP+1 / HP-1
  task automatic send_chip(input logic c);
    int len;
    len = HP;
    if (jit) begin
      len  = jtog ? HP + 1 : HP - 1;
      jtog = ~jtog;
    end
    rx_in = c;
    repeat (len) @(negedge clk);
  endtask

  task automatic send_bit(input logic b);
    send_chip(~b);
    send_chip(b);
  endtask

  task automatic send_byte(input logic [7:0] w);
    for (int i = 7; i >= 0; i--) send_bit(w[i]);
  endtask

  task automatic send_frame(input logic [7:0] w);
    send_byte(8'hD5);
    send_byte(w);
`ifdef BSG_RX_PARITY_EN
    send_bit(^w);
`endif
  endtask

  task automatic idle(input int n);
    rx_in = 1'b0;
    repeat (n) @(negedge clk);
  endtask

  int base;

  initial begin
    rst    = 1'b1;
    enable = 1'b1;
    rx_in  = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_data_out", data_out, 0);
    check("rst_data_valid", data_valid, 0);
    check("rst_code_err", code_err, 0);
    check("rst_busy", busy, 0);
    rst = 1'b0;
    idle(12);

    // Clean frame with exact output latency
    send_frame(8'hA5);
    check("clean_dv_before", data_valid, 0);
    check("clean_busy_last_chip", busy, 1);
    @(negedge clk);
    check("clean_dv_pulse", data_valid, 1);
    check("clean_data", data_out, 8'hA5);
    check("clean_no_err", code_err, 0);
    check("clean_busy_after", busy, 0);
    @(negedge clk);
    check("clean_dv_one_cycle", data_valid, 0);
    idle(10);
    check("clean_dv_count", dv_cnt, 1);

    // Reset mid-frame
    send_byte(8'hD5);
    send_bit(1'b1); send_bit(1'b0); send_bit(1'b0); send_bit(1'b1);
    check("midframe_busy", busy, 1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("midrst_data_out", data_out, 0);
    check("midrst_data_valid", data_valid, 0);
    check("midrst_code_err", code_err, 0);
    check("midrst_busy", busy, 0);
    send_bit(1'b0); send_bit(1'b1); send_bit(1'b1); send_bit(1'b0);
    idle(20);
    check("midrst_no_dv", dv_cnt, 1);
    send_frame(8'h3C);
    idle(10);
    check("after_rst_dv_count", dv_cnt, 2);
    check("after_rst_data", data_out, 8'h3C);

    // Code violation on the third data bit
    send_byte(8'hD5);
    send_bit(1'b1); send_bit(1'b0);
    send_chip(1'b1); send_chip(1'b1);
    idle(20);
    check("viol_err_count", err_cnt, 1);
    check("viol_data_held", data_out, 8'h3C);
    check("viol_no_dv", dv_cnt, 2);
    send_frame(8'h0F);
    idle(10);
    check("post_viol_data", data_out, 8'h0F);
    check("post_viol_dv_count", dv_cnt, 3);

    // Jittered chips
    jit = 1'b1;
    send_frame(8'h5A);
    jit = 1'b0;
    idle(10);
    check("jitter_data", data_out, 8'h5A);
    check("jitter_no_err", err_cnt, 1);
    check("jitter_dv_count", dv_cnt, 4);

    // Back-to-back frames
    base = dv_log.size();
    send_frame(8'h01);
    send_frame(8'hFE);
    idle(10);
    check("b2b_dv_count", dv_cnt, 6);
    check("b2b_first", dv_log[base], 8'h01);
    check("b2b_second", dv_log[base+1], 8'hFE);

    // Enable low across the sync word
    enable = 1'b0;
    send_byte(8'hD5);
    enable = 1'b1;
    send_byte(8'h01);
`ifdef BSG_RX_PARITY_EN
    send_bit(1'b1);
`endif
    idle(10);
    check("en_low_no_dv", dv_cnt, 6);
    check("en_low_data_held", data_out, 8'hFE);
    check("en_low_no_err", err_cnt, 1);

`ifdef BSG_RX_PARITY_EN
    // Good and bad parity on 0x03
    send_byte(8'hD5); send_byte(8'h03); send_bit(1'b0);
    idle(10);
    check("par_good_dv", dv_cnt, 7);
    check("par_good_data", data_out, 8'h03);
    send_byte(8'hD5); send_byte(8'hA5); send_bit(1'b1);
    idle(10);
    check("par_bad_err", err_cnt, 2);
    check("par_bad_data_held", data_out, 8'h03);
    check("par_bad_no_dv", dv_cnt, 7);
`else
    send_frame(8'h03);
    idle(10);
    check("last_dv", dv_cnt, 7);
    check("last_data", data_out, 8'h03);
`endif

    check("dv_err_exclusive", both_seen, 0);
    $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
    $finish;
  end

endmodule
